// File: rtl/mem_pkg.sv
// Shared widths, codes and helpers for the memory-access pipeline stage.
package mem_pkg;

    localparam int WORD_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int INSTR_W   = 32;
    localparam int REG_IDX_W = 5;

    localparam int MEM_COUNT_W = 2;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd0;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd1;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd2;

    localparam int DEST_SRC_W = 2;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE = 2'd0;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_ALU  = 2'd1;
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_MEM  = 2'd2;

    // Instruction bit that selects zero-extension for sub-word loads.
    localparam int UNSIGNED_BIT = 14;

    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [MEM_COUNT_W-1:0] count);
        logic mis;
        mis = 1'b0;
        case (count)
            MEM_COUNT_HALF: mis = addr_lo[0];
            MEM_COUNT_WORD: mis = (addr_lo != 2'b00);
            default:        mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero
// extension for loads. Purely combinational.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]             addr_lo,
    input  logic [MEM_COUNT_W-1:0] count,
    input  logic                   is_unsigned,
    input  logic [WORD_W-1:0]      wr_data,
    input  logic [WORD_W-1:0]      rd_data,
    output logic [3:0]             be,
    output logic [WORD_W-1:0]      lane_wr_data,
    output logic [WORD_W-1:0]      rd_ext
);

    logic [WORD_W-1:0] rd_byte_shift;
    logic [WORD_W-1:0] rd_half_shift;

    assign rd_byte_shift = rd_data >> {addr_lo, 3'b000};
    assign rd_half_shift = rd_data >> {addr_lo[1], 4'b0000};

    always_comb begin
        be           = 4'b1111;
        lane_wr_data = wr_data;
        rd_ext       = rd_data;
        case (count)
            MEM_COUNT_BYTE: begin
                be           = 4'b0001 << addr_lo;
                lane_wr_data = {4{wr_data[7:0]}};
                rd_ext       = is_unsigned
                             ? {{(WORD_W-8){1'b0}}, rd_byte_shift[7:0]}
                             : {{(WORD_W-8){rd_byte_shift[7]}}, rd_byte_shift[7:0]};
            end
            MEM_COUNT_HALF: begin
                be           = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wr_data = {2{wr_data[15:0]}};
                rd_ext       = is_unsigned
                             ? {{(WORD_W-16){1'b0}}, rd_half_shift[15:0]}
                             : {{(WORD_W-16){rd_half_shift[15]}}, rd_half_shift[15:0]};
            end
            default: begin
                be           = 4'b1111;
                lane_wr_data = wr_data;
                rd_ext       = rd_data;
            end
        endcase
    end

endmodule

// File: rtl/mem.sv
// Memory-access pipeline stage: registers execute results, runs one req/ack
// data-memory transaction per aligned load/store and presents writeback data.
module mem
    import mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   stall,
    input  logic [ADDR_W-1:0]      i_pc,
    input  logic [INSTR_W-1:0]     i_instr,
    input  logic [DEST_SRC_W-1:0]  i_dest_src,
    input  logic [REG_IDX_W-1:0]   i_dest_reg,
    input  logic [WORD_W-1:0]      i_alu_eval,
    input  logic                   i_mem_req_en,
    input  logic [ADDR_W-1:0]      i_mem_req_addr,
    input  logic [WORD_W-1:0]      i_mem_req_wr_data,
    input  logic                   i_mem_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_mem_req_count,
    output logic                   o_dmem_req,
    output logic [ADDR_W-1:0]      o_dmem_addr,
    output logic                   o_dmem_wr_en,
    output logic [3:0]             o_dmem_be,
    output logic [WORD_W-1:0]      o_dmem_wr_data,
    input  logic                   i_dmem_ack,
    input  logic [WORD_W-1:0]      i_dmem_rd_data,
    output logic [ADDR_W-1:0]      o_pc,
    output logic [INSTR_W-1:0]     o_instr,
    output logic [DEST_SRC_W-1:0]  o_dest_src,
    output logic [REG_IDX_W-1:0]   o_dest_reg,
    output logic [WORD_W-1:0]      o_wb_data,
    output logic                   o_busy,
    output logic                   o_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    state_e                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   fault_q, fault_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]     instr_q, instr_d;
    logic [DEST_SRC_W-1:0]  dest_src_q, dest_src_d;
    logic [REG_IDX_W-1:0]   dest_reg_q, dest_reg_d;
    logic [WORD_W-1:0]      alu_q, alu_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [WORD_W-1:0]      wdata_q, wdata_d;
    logic                   wr_en_q, wr_en_d;
    logic [MEM_COUNT_W-1:0] count_q, count_d;
    logic [WORD_W-1:0]      rd_fmt_q, rd_fmt_d;

    logic              capture;
    logic              capture_mis;
    logic              capture_mem;
    logic              timeout_hit;
    logic              in_req;
    logic [3:0]        be_w;
    logic [WORD_W-1:0] lane_wr_data;
    logic [WORD_W-1:0] rd_ext;

    assign in_req      = (state_q == S_REQ);
    assign capture     = !stall && !in_req;
    assign capture_mis = i_mem_req_en && is_misaligned(i_mem_req_addr[1:0], i_mem_req_count);
    assign capture_mem = i_mem_req_en && !capture_mis;
    // The counter holds the number of ack-less cycles already spent, so the
    // current cycle is the MAX_WAIT-th when counter + 1 reaches MAX_WAIT.
    assign timeout_hit = (MAX_WAIT != 0) && ((32'(wait_q) + 32'd1) >= MAX_WAIT);

    mem_align u_align (
        .addr_lo      (addr_q[1:0]),
        .count        (count_q),
        .is_unsigned  (instr_q[UNSIGNED_BIT]),
        .wr_data      (wdata_q),
        .rd_data      (i_dmem_rd_data),
        .be           (be_w),
        .lane_wr_data (lane_wr_data),
        .rd_ext       (rd_ext)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        fault_d    = fault_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        dest_src_d = dest_src_q;
        dest_reg_d = dest_reg_q;
        alu_d      = alu_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_en_d    = wr_en_q;
        count_d    = count_q;
        rd_fmt_d   = rd_fmt_q;

        if (capture) begin
            pc_d       = i_pc;
            instr_d    = i_instr;
            dest_src_d = i_dest_src;
            dest_reg_d = i_dest_reg;
            alu_d      = i_alu_eval;
            addr_d     = i_mem_req_addr;
            wdata_d    = i_mem_req_wr_data;
            wr_en_d    = i_mem_req_wr_en;
            count_d    = i_mem_req_count;
            // A misaligned or non-memory op has no load result.
            rd_fmt_d   = '0;
            if (capture_mis) begin
                fault_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (capture && capture_mem) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (i_dmem_ack) begin
                    rd_fmt_d = rd_ext;
                    wait_d   = '0;
                    state_d  = S_DONE;
                end else if (timeout_hit) begin
                    rd_fmt_d = '0;
                    fault_d  = 1'b1;
                    wait_d   = '0;
                    state_d  = S_DONE;
                end else if (MAX_WAIT != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DONE: begin
                wait_d = '0;
                if (capture) begin
                    state_d = capture_mem ? S_REQ : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            fault_q    <= 1'b0;
            pc_q       <= '0;
            instr_q    <= '0;
            dest_src_q <= DEST_SRC_NONE;
            dest_reg_q <= '0;
            alu_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
            count_q    <= '0;
            rd_fmt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            fault_q    <= fault_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            dest_src_q <= dest_src_d;
            dest_reg_q <= dest_reg_d;
            alu_q      <= alu_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            count_q    <= count_d;
            rd_fmt_q   <= rd_fmt_d;
        end
    end

    // Memory-port fields are only meaningful while requesting; keep them quiet otherwise.
    assign o_dmem_req     = in_req;
    assign o_dmem_addr    = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign o_dmem_wr_en   = in_req && wr_en_q;
    assign o_dmem_be      = in_req ? be_w : 4'b0000;
    assign o_dmem_wr_data = in_req ? lane_wr_data : '0;

    assign o_pc       = pc_q;
    assign o_instr    = instr_q;
    assign o_dest_src = dest_src_q;
    assign o_dest_reg = dest_reg_q;
    assign o_wb_data  = (dest_src_q == DEST_SRC_MEM) ? rd_fmt_q : alu_q;
    assign o_busy     = in_req;
    assign o_fault    = fault_q;

endmodule

// File: tb/tb_mem.sv
// Randomized bench for the memory-access stage: a per-op timeline model
// predicts every output each cycle; directed cases pin the model to literals.
module tb_mem;
    import mem_pkg::*;

    localparam int MAXW = 4;

    logic                   clk = 1'b0;
    logic                   clr;
    logic                   stall;
    logic [ADDR_W-1:0]      i_pc;
    logic [INSTR_W-1:0]     i_instr;
    logic [DEST_SRC_W-1:0]  i_dest_src;
    logic [REG_IDX_W-1:0]   i_dest_reg;
    logic [WORD_W-1:0]      i_alu_eval;
    logic                   i_mem_req_en;
    logic [ADDR_W-1:0]      i_mem_req_addr;
    logic [WORD_W-1:0]      i_mem_req_wr_data;
    logic                   i_mem_req_wr_en;
    logic [MEM_COUNT_W-1:0] i_mem_req_count;
    logic                   o_dmem_req;
    logic [ADDR_W-1:0]      o_dmem_addr;
    logic                   o_dmem_wr_en;
    logic [3:0]             o_dmem_be;
    logic [WORD_W-1:0]      o_dmem_wr_data;
    logic                   i_dmem_ack;
    logic [WORD_W-1:0]      i_dmem_rd_data;
    logic [ADDR_W-1:0]      o_pc;
    logic [INSTR_W-1:0]     o_instr;
    logic [DEST_SRC_W-1:0]  o_dest_src;
    logic [REG_IDX_W-1:0]   o_dest_reg;
    logic [WORD_W-1:0]      o_wb_data;
    logic                   o_busy;
    logic                   o_fault;

    mem #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .clr(clr), .stall(stall),
        .i_pc(i_pc), .i_instr(i_instr), .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg),
        .i_alu_eval(i_alu_eval), .i_mem_req_en(i_mem_req_en), .i_mem_req_addr(i_mem_req_addr),
        .i_mem_req_wr_data(i_mem_req_wr_data), .i_mem_req_wr_en(i_mem_req_wr_en),
        .i_mem_req_count(i_mem_req_count),
        .o_dmem_req(o_dmem_req), .o_dmem_addr(o_dmem_addr), .o_dmem_wr_en(o_dmem_wr_en),
        .o_dmem_be(o_dmem_be), .o_dmem_wr_data(o_dmem_wr_data),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rd_data(i_dmem_rd_data),
        .o_pc(o_pc), .o_instr(o_instr), .o_dest_src(o_dest_src), .o_dest_reg(o_dest_reg),
        .o_wb_data(o_wb_data), .o_busy(o_busy), .o_fault(o_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  dsrc;
        logic [1:0]  cnt;
        logic [4:0]  dreg;
        logic        en;
        logic        we;
        int          d;       // ack comes in S_REQ cycle d+1
        int          clr_at;  // assert clr in this S_REQ cycle (0 = never)
        int          pre;     // stalled cycles before presenting the op
        logic        pre_ack; // force a stray ack during those cycles
    } op_t;

    int checks = 0;
    int errors = 0;
    int req_total = 0;
    logic [31:0] snap_addr, snap_wd;
    logic [3:0]  snap_be;

    logic        chk_en = 1'b0;
    logic        exp_zero, exp_req, exp_busy, exp_fault, exp_we, m_fault;
    logic [31:0] exp_pc, exp_instr, exp_alu_wb, exp_addr, exp_wd;
    logic [1:0]  exp_dsrc;
    logic [4:0]  exp_dreg;
    logic [3:0]  exp_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(o_busy), 32'(exp_busy));
            chk("req", 32'(o_dmem_req), 32'(exp_req));
            chk("fault", 32'(o_fault), 32'(exp_fault));
            chk("pc", o_pc, exp_pc);
            chk("instr", o_instr, exp_instr);
            chk("dest_src", 32'(o_dest_src), 32'(exp_dsrc));
            chk("dest_reg", 32'(o_dest_reg), 32'(exp_dreg));
            if (exp_req || exp_zero) begin
                chk("dmem_addr", o_dmem_addr, exp_addr);
                chk("dmem_we", 32'(o_dmem_wr_en), 32'(exp_we));
                chk("dmem_be", 32'(o_dmem_be), 32'(exp_be));
                chk("dmem_wd", o_dmem_wr_data, exp_wd);
            end
            if (!exp_busy) chk("wb_data", o_wb_data, exp_alu_wb);
        end
        if (o_dmem_req === 1'b1) begin
            req_total = req_total + 1;
            snap_addr = o_dmem_addr;
            snap_be   = o_dmem_be;
            snap_wd   = o_dmem_wr_data;
        end
    end

    function automatic logic model_mis(input logic [31:0] addr, input logic [1:0] cnt);
        return (cnt == 2'd1 && (addr % 2) == 1) || (cnt == 2'd2 && (addr % 4) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] cnt);
        int a = int'(addr % 4);
        if (cnt == 2'd0) return 4'(1 << a);
        if (cnt == 2'd1) return (a >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wd(input logic [31:0] data, input logic [1:0] cnt);
        if (cnt == 2'd0) return (data % 256) * 32'h0101_0101;
        if (cnt == 2'd1) return (data % 65536) * 32'h0001_0001;
        return data;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] addr,
                                               input logic [1:0] cnt, input logic uns);
        logic [31:0] v = rd >> (8 * (addr % 4));
        if (cnt == 2'd0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v - 32'd256;
        end else if (cnt == 2'd1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_zero();
        exp_zero = 1'b1; exp_req = 1'b0; exp_busy = 1'b0; exp_fault = 1'b0; m_fault = 1'b0;
        exp_pc = '0; exp_instr = '0; exp_dsrc = DEST_SRC_NONE; exp_dreg = '0; exp_alu_wb = '0;
        exp_addr = '0; exp_we = 1'b0; exp_be = '0; exp_wd = '0;
    endtask

    task automatic drive_junk();
        i_pc = $urandom; i_instr = $urandom; i_dest_src = 2'($urandom_range(2, 0));
        i_dest_reg = 5'($urandom); i_alu_eval = $urandom; i_mem_req_en = 1'($urandom);
        i_mem_req_addr = $urandom; i_mem_req_wr_data = $urandom; i_mem_req_wr_en = 1'($urandom);
        i_mem_req_count = 2'($urandom_range(2, 0));
    endtask

    task automatic do_clr();
        clr = 1'b1; stall = 1'($urandom); i_dmem_ack = 1'($urandom); drive_junk();
        step();
        set_zero();
        clr = 1'b0;
    endtask

    function automatic op_t rand_op();
        op_t o;
        int kind = int'($urandom_range(2, 0));
        o.pc = $urandom; o.instr = $urandom; o.alu = $urandom; o.addr = $urandom;
        o.wd = $urandom; o.rd = $urandom; o.dreg = 5'($urandom);
        o.cnt = 2'($urandom_range(2, 0));
        o.en = (kind != 0); o.we = (kind == 2);
        o.dsrc = (kind == 1) ? DEST_SRC_MEM : (kind == 2) ? DEST_SRC_NONE
               : ($urandom_range(1, 0) == 1 ? DEST_SRC_ALU : DEST_SRC_NONE);
        o.d = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 4)) : int'($urandom_range(3, 0));
        o.clr_at = ($urandom_range(11, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
        o.pre = int'($urandom_range(2, 0));
        o.pre_ack = 1'b0;
        return o;
    endfunction

    task automatic run_op(input op_t op);
        logic mis, memop, tmo;
        int   nreq;
        for (int k = 0; k < op.pre; k++) begin
            drive_junk(); stall = 1'b1;
            i_dmem_ack = op.pre_ack ? 1'b1 : 1'($urandom); i_dmem_rd_data = $urandom;
            step();
        end
        i_pc = op.pc; i_instr = op.instr; i_dest_src = op.dsrc; i_dest_reg = op.dreg;
        i_alu_eval = op.alu; i_mem_req_en = op.en; i_mem_req_addr = op.addr;
        i_mem_req_wr_data = op.wd; i_mem_req_wr_en = op.we; i_mem_req_count = op.cnt;
        stall = 1'b0; i_dmem_ack = 1'($urandom); i_dmem_rd_data = $urandom;
        step();
        exp_zero = 1'b0; exp_pc = op.pc; exp_instr = op.instr; exp_dsrc = op.dsrc; exp_dreg = op.dreg;
        mis = op.en && model_mis(op.addr, op.cnt);
        memop = op.en && !mis;
        if (mis) m_fault = 1'b1;
        exp_fault = m_fault;
        if (!memop) begin
            exp_req = 1'b0; exp_busy = 1'b0;
            exp_alu_wb = (op.dsrc == DEST_SRC_MEM) ? 32'd0 : op.alu;
            return;
        end
        tmo  = (op.d + 1 > MAXW);
        nreq = tmo ? MAXW : op.d + 1;
        for (int i = 1; i <= nreq; i++) begin
            exp_req = 1'b1; exp_busy = 1'b1;
            exp_addr = op.addr & 32'hFFFF_FFFC; exp_we = op.we;
            exp_be = model_be(op.addr, op.cnt); exp_wd = model_wd(op.wd, op.cnt);
            drive_junk(); stall = 1'($urandom);
            i_dmem_ack = (i == op.d + 1); i_dmem_rd_data = i_dmem_ack ? op.rd : $urandom;
            if (i == op.clr_at) begin
                i_dmem_ack = 1'b0; clr = 1'b1;
                step();
                clr = 1'b0;
                set_zero();
                return;
            end
            step();
        end
        exp_req = 1'b0; exp_busy = 1'b0;
        if (tmo) m_fault = 1'b1;
        exp_fault = m_fault;
        if (op.dsrc == DEST_SRC_MEM)
            exp_alu_wb = (!op.we && !tmo) ? model_load(op.rd, op.addr, op.cnt, op.instr[UNSIGNED_BIT]) : 32'd0;
        else
            exp_alu_wb = op.alu;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_t o;
        int  base;
        clr = 1'b1; stall = 1'b0; i_dmem_ack = 1'b0; i_dmem_rd_data = '0; drive_junk();
        step();
        set_zero();
        chk_en = 1'b1;
        step();
        chk("reset_wb", o_wb_data, 32'd0);
        chk("reset_fault", 32'(o_fault), 32'd0);
        clr = 1'b0;

        // Store byte 0xA5 at 0x1003, ack in the third request cycle.
        o = rand_op(); o.en = 1; o.we = 1; o.cnt = MEM_COUNT_BYTE; o.addr = 32'h0000_1003;
        o.wd = 32'h0000_00A5; o.dsrc = DEST_SRC_NONE; o.d = 2; o.clr_at = 0; o.pre = 0;
        base = req_total;
        run_op(o);
        chk("sb_req_cycles", 32'(req_total - base), 32'd3);
        chk("sb_addr", snap_addr, 32'h0000_1000);
        chk("sb_be", 32'(snap_be), 32'h8);
        chk("sb_wd", snap_wd, 32'hA5A5_A5A5);

        // Signed / unsigned half loads at 0x2002 with same-cycle ack.
        o = rand_op(); o.en = 1; o.we = 0; o.cnt = MEM_COUNT_HALF; o.addr = 32'h0000_2002;
        o.rd = 32'h8001_1234; o.dsrc = DEST_SRC_MEM; o.d = 0; o.clr_at = 0; o.pre = 0;
        o.instr[UNSIGNED_BIT] = 1'b0;
        run_op(o);
        chk("lh_signed", o_wb_data, 32'hFFFF_8001);
        o.instr[UNSIGNED_BIT] = 1'b1;
        run_op(o);
        chk("lh_unsigned", o_wb_data, 32'h0000_8001);

        // Byte load at 0x0001, then an ALU op.
        o = rand_op(); o.en = 1; o.we = 0; o.cnt = MEM_COUNT_BYTE; o.addr = 32'h0000_0001;
        o.rd = 32'h0000_7F00; o.dsrc = DEST_SRC_MEM; o.d = 1; o.clr_at = 0; o.pre = 0;
        run_op(o);
        chk("lb_wb", o_wb_data, 32'h0000_007F);
        o = rand_op(); o.en = 0; o.dsrc = DEST_SRC_ALU; o.alu = 32'h55; o.pre = 0; o.clr_at = 0;
        base = req_total;
        run_op(o);
        chk("alu_wb", o_wb_data, 32'h55);
        chk("alu_no_req", 32'(req_total - base), 32'd0);

        // Misaligned word store: no request, sticky fault until clr.
        o = rand_op(); o.en = 1; o.we = 1; o.cnt = MEM_COUNT_WORD; o.addr = 32'h0000_0006;
        o.dsrc = DEST_SRC_NONE; o.pre = 0; o.clr_at = 0;
        base = req_total;
        run_op(o);
        chk("mis_fault", 32'(o_fault), 32'd1);
        for (int k = 0; k < 3; k++) begin
            o = rand_op(); o.en = 0; o.clr_at = 0;
            run_op(o);
        end
        chk("mis_no_req", 32'(req_total - base), 32'd0);
        chk("mis_fault_sticky", 32'(o_fault), 32'd1);
        do_clr();
        chk("clr_fault", 32'(o_fault), 32'd0);

        // Timeout, then a stray ack while idle.
        o = rand_op(); o.en = 1; o.we = 0; o.cnt = MEM_COUNT_WORD; o.addr = 32'h0000_0010;
        o.dsrc = DEST_SRC_MEM; o.d = 9; o.clr_at = 0; o.pre = 0;
        base = req_total;
        run_op(o);
        chk("tmo_req_cycles", 32'(req_total - base), 32'd4);
        chk("tmo_fault", 32'(o_fault), 32'd1);
        chk("tmo_wb", o_wb_data, 32'd0);
        o = rand_op(); o.en = 0; o.clr_at = 0; o.pre = 0;
        run_op(o);
        o = rand_op(); o.clr_at = 0; o.pre = 3; o.pre_ack = 1'b1;
        run_op(o);

        // clr in the second request cycle, then a normal load.
        do_clr();
        o = rand_op(); o.en = 1; o.we = 0; o.cnt = MEM_COUNT_BYTE; o.addr = 32'h0000_0020;
        o.dsrc = DEST_SRC_MEM; o.d = 9; o.clr_at = 2; o.pre = 0;
        run_op(o);
        chk("clr_req", 32'(o_dmem_req), 32'd0);
        chk("clr_busy", 32'(o_busy), 32'd0);
        chk("clr_pc", o_pc, 32'd0);
        o = rand_op(); o.en = 1; o.we = 0; o.cnt = MEM_COUNT_WORD; o.addr = 32'h0000_0040;
        o.rd = 32'hDEAD_BEEF; o.dsrc = DEST_SRC_MEM; o.d = 1; o.clr_at = 0; o.pre = 0;
        run_op(o);
        chk("post_clr_lw", o_wb_data, 32'hDEAD_BEEF);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(39, 0) == 0) do_clr();
            run_op(rand_op());
        end
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem.md
Name: mem

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of writeback.
- Registers the execute-stage results and runs a req/ack transaction on the data-memory port for loads and stores.
- Performs store byte-lane alignment and load extraction with sign/zero extension.
- Holds the pipeline via o_busy while a transaction is outstanding, then presents the register-writeback value.

Parameters:
- MAX_WAIT, 255: max cycles in S_REQ without ack before abort; 0 disables the timeout.
- All widths come from config.vh macros: WORD_W=32, ADDR_W=32, INSTR_W=32, REG_IDX_W=5.

Ports:
- clk  in  1  clock, all state on posedge.
- clr  in  1  reset, synchronous, active-high.
- stall  in  1  global hold from the hazard unit.
- i_pc  in  ADDR_W  pc from execute.
- i_instr  in  INSTR_W  instruction from execute; bit 14 set = unsigned load.
- i_dest_src  in  DEST_SRC_W  writeback source select.
- i_dest_reg  in  REG_IDX_W  destination register.
- i_alu_eval  in  WORD_W  ALU result (pass-through value).
- i_mem_req_en  in  1  instruction is a load or store.
- i_mem_req_addr  in  ADDR_W  byte address.
- i_mem_req_wr_data  in  WORD_W  store data, right-aligned.
- i_mem_req_wr_en  in  1  1 = store, 0 = load.
- i_mem_req_count  in  MEM_COUNT_W  MEM_COUNT_BYTE, MEM_COUNT_HALF or MEM_COUNT_WORD.
- o_dmem_req  out  1  request valid.
- o_dmem_addr  out  ADDR_W  word-aligned address {addr[31:2],2'b00}.
- o_dmem_wr_en  out  1  write strobe qualifier.
- o_dmem_be  out  4  byte enables.
- o_dmem_wr_data  out  WORD_W  lane-replicated store data.
- i_dmem_ack  in  1  transaction complete; read data valid this cycle.
- i_dmem_rd_data  in  WORD_W  read word.
- o_pc, o_instr, o_dest_src, o_dest_reg  out  stage-register copies.
- o_wb_data  out  WORD_W  formatted load data if dest_src==DEST_SRC_MEM, else the registered alu_eval.
- o_busy  out  1  stage cannot accept; the hazard unit ORs it into stall.
- o_fault  out  1  sticky: misaligned access or timeout; cleared only by clr.

Behaviour:
- Stage registers capture on posedge when clr==0 && stall==0 && o_busy==0.
- On clr, the next edge forces:
  - all outputs 0;
  - dest_src = DEST_SRC_NONE;
  - state = S_IDLE;
  - wait counter = 0;
  - o_fault = 0.
- Misaligned access: half with addr[0]==1, or word with addr[1:0]!=0.
  - No request is issued.
  - o_fault is set.
  - Load result is 0.
  - The instruction is treated as a non-memory op.
- FSM states: S_IDLE, S_REQ, S_DONE.
- S_IDLE: o_busy=0, o_dmem_req=0. A capture of an aligned mem op moves to S_REQ; anything else stays.
- S_REQ: o_dmem_req=1, o_busy=1.
  - Address, be, wr_data and wr_en are driven combinationally from the stage registers and held stable until ack.
  - Wait counter increments each cycle without ack.
  - On i_dmem_ack: latch the formatted load data and go to S_DONE. Same-cycle ack is legal.
  - If MAX_WAIT!=0 and the counter reaches MAX_WAIT with no ack: drop req, set o_fault, load data = 0, go to S_DONE.
- S_DONE: o_dmem_req=0, o_busy=0, o_wb_data valid.
  - A capture of a new aligned mem op moves to S_REQ; otherwise go to S_IDLE.
  - If stall holds the stage, remain in S_DONE with outputs unchanged.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: 1 + number of S_REQ cycles (minimum 2).
  - Exactly one request per captured mem op; no re-issue while stalled.
- Store formatting:
  - byte: be = 4'b0001 << addr[1:0], wr_data = {4{data[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011, wr_data = {2{data[15:0]}}.
  - word: be = 4'b1111.
- Load formatting:
  - Select the byte or half lane by addr[1:0].
  - Sign-extend when instr[14]==0, zero-extend when 1.
  - Word loads pass through.
- Ack arriving in S_IDLE or S_DONE (late, or after clr) is ignored.
- clr during S_REQ: req deasserts from the following cycle and the transaction is abandoned.

Decomposition:
- Shared in mem_codes.vh:
  - MEM_COUNT_BYTE/HALF/WORD and MEM_COUNT_W;
  - DEST_SRC_NONE/ALU/MEM and DEST_SRC_W.
- FSM state encodings are local parameters.
- One combinational sub-module, mem_align: (addr[1:0], count, unsigned, wr_data, rd_data) -> (be, lane wr_data, extended rd_data). It can be unit-tested exhaustively.

Test Plan:
- Store byte 0xA5 at 0x1003, ack after 3 cycles:
  - o_dmem_addr=0x1000, be=4'b1000, wr_data=0xA5A5A5A5;
  - req held 3 cycles then drops;
  - o_busy high until the ack cycle inclusive.
- Load half signed at 0x2002, rd_data=0x8001_1234, same-cycle ack:
  - o_wb_data=0xFFFF8001 in S_DONE; with instr[14]=1, 0x00008001.
- Load byte at 0x0001 with rd_data=0x00007F00, dest_src=MEM: o_wb_data=0x0000007F. Then an ALU op with alu_eval=0x55: o_wb_data=0x55 one cycle later, no req.
- Word store at 0x0006: o_dmem_req never asserts, o_fault=1 and stays 1 until clr.
- MAX_WAIT=4, no ack:
  - req high exactly 4 cycles;
  - o_fault=1, load data 0;
  - a late ack in S_IDLE causes no change.
- clr asserted in the 2nd S_REQ cycle:
  - next cycle req=0, state S_IDLE, all outputs 0, o_busy=0;
  - a following load completes normally.
